// File: rtl/halfband_decim2_sym_if.sv
// ============================================================================
// halfband_decim2_sym_if : sample/coefficient/status bundle for the halfband
// Revision : 1.0
// ============================================================================
`default_nettype none

interface halfband_decim2_sym_if #(
  parameter int WIDTH  = 18,
  parameter int COEF_W = 18,
  parameter int NTAPS  = 15
);
  localparam int NU = (NTAPS + 1) / 4;
  localparam int AW = $clog2(NU + 1);

  logic                     sam_clk_en;
  logic signed [WIDTH-1:0]  x_in;
  logic [1:0]               mode;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     sat_clr;
  logic signed [WIDTH-1:0]  y;
  logic                     y_valid;
  logic                     sat_flag;

  modport master (
    output sam_clk_en, x_in, mode, coef_we, coef_addr, coef_data, sat_clr,
    input  y, y_valid, sat_flag
  );

  modport slave (
    input  sam_clk_en, x_in, mode, coef_we, coef_addr, coef_data, sat_clr,
    output y, y_valid, sat_flag
  );
endinterface

`default_nettype wire

// File: rtl/halfband_decim2_sym.sv
// ============================================================================
// halfband_decim2_sym : symmetric halfband FIR with filter/decimate/bypass modes
// Revision : 1.0
// ============================================================================
`default_nettype none

module halfband_decim2_sym #(
  parameter int WIDTH  = 18,
  parameter int COEF_W = 18,
  parameter int NTAPS  = 15
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  halfband_decim2_sym_if.slave bus
);
  localparam int NU     = (NTAPS + 1) / 4;
  localparam int C      = (NTAPS - 1) / 2;
  localparam int T      = $clog2(NU + 1);
  localparam int LAT    = 3 + T;
  localparam int AW     = $clog2(NU + 1);
  localparam int PW     = WIDTH + 1;
  localparam int MW     = PW + COEF_W;
  localparam int ACC_W  = MW + T;
  localparam int LEAVES = 2 ** T;

  localparam logic [1:0] MODE_FILT = 2'd0;
  localparam logic [1:0] MODE_DEC  = 2'd1;
  localparam logic [1:0] MODE_BYP  = 2'd2;

  localparam logic signed [ACC_W:0] RND  = (ACC_W + 1)'(1) << (COEF_W - 2);
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W + 2 - WIDTH){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W + 2 - WIDTH){1'b1}}, {(WIDTH - 1){1'b0}}};

  // Coefficients are not reset; they only take their power-up values.
  logic signed [COEF_W-1:0] side_coef [NU] = '{default: '0};
  logic signed [COEF_W-1:0] centre_coef    = {2'b01, {(COEF_W - 2){1'b0}}};
  logic signed [COEF_W-1:0] coef_all [NU+1];

  logic signed [WIDTH-1:0]  taps [NTAPS];
  logic signed [PW-1:0]     pre  [NU+1];
  logic signed [MW-1:0]     prod [NU+1];
  logic signed [ACC_W-1:0]  leaf [LEAVES];
  logic signed [ACC_W-1:0]  tree [T][LEAVES/2];
  logic signed [WIDTH-1:0]  byp  [T+1];

  logic [1:0]     mode_n, mode_q;
  logic           phase, cur_phase, accept_valid;
  logic [LAT-1:0] tok_v, tok_b;

  logic signed [ACC_W:0]   rnd, shifted;
  logic                    hi, lo, clip;
  logic signed [WIDTH-1:0] sat_val;

  always_ff @(posedge sys_clk) begin
    if (bus.coef_we) begin
      for (int j = 0; j < NU; j++)
        if (bus.coef_addr == AW'(j)) side_coef[j] <= bus.coef_data;
      if (bus.coef_addr == AW'(NU)) centre_coef <= bus.coef_data;
    end
  end

  always_comb begin
    for (int j = 0; j < NU; j++) coef_all[j] = side_coef[j];
    coef_all[NU] = centre_coef;
  end

  // A mode change restarts decimation phase on the very sample that carries it.
  always_comb begin
    mode_n       = (bus.mode == 2'd3) ? MODE_FILT : bus.mode;
    cur_phase    = (mode_n != mode_q) ? 1'b0 : phase;
    accept_valid = (mode_n != MODE_DEC) || cur_phase;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) taps[k] <= '0;
      mode_q <= MODE_FILT;
      phase  <= 1'b0;
      tok_v  <= '0;
      tok_b  <= '0;
    end else begin
      tok_v <= {tok_v[LAT-2:0], bus.sam_clk_en & accept_valid};
      tok_b <= {tok_b[LAT-2:0], mode_n == MODE_BYP};
      if (bus.sam_clk_en) begin
        taps[0] <= bus.x_in;
        for (int k = 1; k < NTAPS; k++) taps[k] <= taps[k-1];
        mode_q <= mode_n;
        phase  <= ~cur_phase;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int j = 0; j <= NU; j++) begin
        pre[j]  <= '0;
        prod[j] <= '0;
      end
      for (int k = 0; k <= T; k++) byp[k] <= '0;
    end else begin
      for (int j = 0; j < NU; j++)
        pre[j] <= PW'(taps[2*j]) + PW'(taps[NTAPS-1-2*j]);
      pre[NU] <= PW'(taps[C]);
      for (int j = 0; j <= NU; j++)
        prod[j] <= MW'(pre[j]) * MW'(coef_all[j]);
      byp[0] <= pre[NU][WIDTH-1:0];
      for (int k = 1; k <= T; k++) byp[k] <= byp[k-1];
    end
  end

  always_comb begin
    for (int i = 0; i < LEAVES; i++) leaf[i] = '0;
    for (int j = 0; j <= NU; j++) leaf[j] = ACC_W'(prod[j]);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int l = 0; l < T; l++)
        for (int i = 0; i < LEAVES / 2; i++) tree[l][i] <= '0;
    end else begin
      for (int i = 0; i < LEAVES / 2; i++)
        tree[0][i] <= leaf[2*i] + leaf[2*i+1];
      for (int l = 1; l < T; l++)
        for (int i = 0; i < (LEAVES >> (l + 1)); i++)
          tree[l][i] <= tree[l-1][2*i] + tree[l-1][2*i+1];
    end
  end

  always_comb begin
    rnd     = (ACC_W + 1)'(tree[T-1][0]) + RND;
    shifted = rnd >>> (COEF_W - 1);
    hi      = shifted > MAXV;
    lo      = shifted < MINV;
    sat_val = hi ? MAXV[WIDTH-1:0] : (lo ? MINV[WIDTH-1:0] : shifted[WIDTH-1:0]);
    clip    = tok_v[LAT-1] && !tok_b[LAT-1] && (hi || lo);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      bus.y        <= '0;
      bus.y_valid  <= 1'b0;
      bus.sat_flag <= 1'b0;
    end else begin
      bus.y_valid <= tok_v[LAT-1];
      if (tok_v[LAT-1]) bus.y <= tok_b[LAT-1] ? byp[T] : sat_val;
      if (clip)             bus.sat_flag <= 1'b1;
      else if (bus.sat_clr) bus.sat_flag <= 1'b0;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_halfband_decim2_sym.sv
// ============================================================================
// tb_halfband_decim2_sym : directed + random bench with a tap-sum reference model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_halfband_decim2_sym;
  localparam int WIDTH = 18, COEF_W = 18, NTAPS = 15;
  localparam int NU = 4, C = 7, LAT = 6;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 sys_clk = ~sys_clk;

  halfband_decim2_sym_if #(.WIDTH(WIDTH), .COEF_W(COEF_W), .NTAPS(NTAPS)) bus ();

  halfband_decim2_sym #(.WIDTH(WIDTH), .COEF_W(COEF_W), .NTAPS(NTAPS)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  typedef struct { longint due; longint val; bit clip; } tok_t;

  int      total = 0, bad = 0;
  longint  cyc = 0;
  longint  hist [NTAPS];
  longint  coef_m [NU+1];
  int      mode_m, phase_m;
  bit      sat_m, v_m;
  longint  y_m;
  tok_t    q [$];
  longint  obs [$];
  longint  imp_exp [15] = '{-40, 0, 394, 0, -1962, 0, 17992, 32768, 17992, 0, -1962, 0, 394, 0, -40};

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic longint tap_coef(input int k);
    if (k == C) return coef_m[NU];
    if (k % 2 != 0) return 0;
    return coef_m[((k < C) ? k : NTAPS - 1 - k) / 2];
  endfunction

  // Plain convolution over the full tap vector, then round/shift/clamp.
  function automatic tok_t model_filter(input longint due);
    tok_t   t;
    longint acc = 0;
    longint r;
    for (int k = 0; k < NTAPS; k++) acc += tap_coef(k) * hist[k];
    r = (acc + (64'sd1 <<< (COEF_W - 2))) >>> (COEF_W - 1);
    t.due = due;
    t.clip = (r > 131071) || (r < -131072);
    t.val = (r > 131071) ? 131071 : ((r < -131072) ? -131072 : r);
    return t;
  endfunction

  task automatic tick(input bit en, input longint x, input int md, input bit sclr,
                      input bit rst, input bit cwe, input int caddr, input longint cdata);
    tok_t   e, t;
    int     mn;
    bit     clipped;
    bus.sam_clk_en = en;
    bus.x_in       = WIDTH'(x);
    bus.mode       = 2'(md);
    bus.sat_clr    = sclr;
    bus.coef_we    = cwe;
    bus.coef_addr  = 3'(caddr);
    bus.coef_data  = COEF_W'(cdata);
    reset          = rst;
    @(posedge sys_clk);
    cyc++;
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) hist[k] = 0;
      q.delete();
      mode_m = 0; phase_m = 0; sat_m = 0; y_m = 0; v_m = 0;
    end else begin
      v_m = 0;
      clipped = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        v_m = 1;
        y_m = e.val;
        clipped = e.clip;
      end
      if (clipped) sat_m = 1;
      else if (sclr) sat_m = 0;
      if (en) begin
        mn = (md == 3) ? 0 : md;
        if (mn != mode_m) phase_m = 0;
        for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
        if (mn == 2) begin
          t.due = cyc + LAT; t.val = hist[C]; t.clip = 0;
          q.push_back(t);
        end else if (mn == 0 || phase_m == 1) begin
          q.push_back(model_filter(cyc + LAT));
        end
        phase_m = 1 - phase_m;
        mode_m = mn;
      end
    end
    if (cwe && caddr <= NU) coef_m[caddr] = cdata;
    #1;
    chk("y_valid", bus.y_valid, v_m);
    chk("y", bus.y, y_m);
    chk("sat_flag", bus.sat_flag, sat_m);
  endtask

  task automatic run(input bit en, input longint x, input int md);
    tick(en, x, md, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic wcoef(input int addr, input longint data);
    tick(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, addr, data);
  endtask

  task automatic impulse(input string tag);
    obs.delete();
    run(1'b1, 65536, 0);
    if (bus.y_valid) obs.push_back(bus.y);
    for (int i = 0; i < 30; i++) begin
      run(1'b1, 0, 0);
      if (bus.y_valid && obs.size() < 15) obs.push_back(bus.y);
    end
    chk({tag, "_count"}, obs.size(), 15);
    for (int i = 0; i < 15 && i < obs.size(); i++) chk(tag, obs[i], imp_exp[i]);
  endtask

  initial begin
    longint xr;
    int     md;
    for (int j = 0; j < NU; j++) coef_m[j] = 0;
    coef_m[NU] = 65536;
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 0);

    wcoef(0, -80); wcoef(1, 788); wcoef(2, -3924); wcoef(3, 35984);
    wcoef(4, 65536); wcoef(5, 12345); wcoef(7, -999);
    impulse("impulse");

    for (int i = 0; i < 40; i++) run(1'b1, 10000, 0);
    chk("dc_y", bus.y, 10000);
    chk("dc_sat", bus.sat_flag, 0);

    for (int i = 0; i < 90; i++) run(i % 3 == 0, 10000, 1);
    chk("decim_y", bus.y, 10000);

    for (int i = 0; i < 8; i++) run(1'b0, 0, 0);
    wcoef(3, 131071);
    for (int i = 0; i < 30; i++) run(1'b1, 131071, 0);
    chk("sat_hi_y", bus.y, 131071);
    chk("sat_hi_flag", bus.sat_flag, 1);
    for (int i = 0; i < 30; i++) run(1'b1, -131072, 0);
    chk("sat_lo_y", bus.y, -131072);
    tick(1'b1, -131072, 0, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("sat_clr_while_clip", bus.sat_flag, 1);
    for (int i = 0; i < 25; i++) run(1'b1, 0, 0);
    tick(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("sat_clr_after", bus.sat_flag, 0);
    for (int i = 0; i < 8; i++) run(1'b0, 0, 0);
    wcoef(3, 35984);

    for (int i = 1; i <= 40; i++) run(1'b1, i, 2);
    chk("bypass_delay", bus.y, 27);

    for (int i = 0; i < 3; i++) run(1'b1, 5000 + i, 0);
    tick(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    chk("midreset_y", bus.y, 0);
    for (int i = 0; i < 10; i++) run(1'b0, 0, 0);
    impulse("impulse_again");

    md = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) md = int'($urandom_range(0, 3));
      xr = longint'($urandom_range(0, 262143)) - 131072;
      tick(1'(($urandom_range(0, 2)) != 0), xr, md, 1'($urandom_range(0, 15) == 0),
           1'b0, 1'b0, 0, 0);
    end
    for (int i = 0; i < 10; i++) run(1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
